mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-requester round-robin arbiter and sequencer for the CPU's single shared memory port: instruction fetch (requester 0) and data access (requester 1). It picks a winner, captures that requester's command, drives the 2-to-1 select that steers the port's address/data muxes, and runs a request/acknowledge transaction with a timeout. It returns read data and a completion or error pulse to the owner.

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, data width
- TIMEOUT, 15, max WAIT cycles before abort (1..255; counter 8 bits)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted), deassertion synchronous to clk
- req0, req1  in  1  request, held until matching done/err
- addr0, addr1  in  ADDR_W  request address
- we0, we1  in  1  1 = write, 0 = read
- wdata0, wdata1  in  DATA_W  write data
- gnt0, gnt1  out  1  owner indicator, high from ISSUE through WAIT
- done0, done1  out  1  one-cycle completion pulse
- err0, err1  out  1  one-cycle timeout pulse, exclusive with done
- rdata  out  DATA_W  captured read data, held until next read completes
- sel  out  1  owner select for the port muxes (0 = req0, 1 = req1)
- busy  out  1  high whenever state is not IDLE
- mem_req  out  1  one-cycle command strobe to the port
- mem_addr  out  ADDR_W  registered command address
- mem_we  out  1  registered command write enable
- mem_wdata  out  DATA_W  registered command write data
- mem_ack  in  1  port completion, rdata valid same cycle
- mem_rdata  in  DATA_W  port read data

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE behaviour:
  - With no request, stay in IDLE.
  - With one request, grant it.
  - With both requests, grant the requester that is not last_owner.
  - On grant, latch owner into sel and latch the owner's addr/we/wdata into mem_addr/mem_we/mem_wdata. Go to ISSUE.
- ISSUE: mem_req=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- WAIT, mem_ack=1:
  - If the command was a read, load rdata from mem_rdata. Writes leave rdata unchanged.
  - Pulse done[sel], set last_owner=sel, go to IDLE.
- WAIT, mem_ack=0: increment the counter. When the counter reaches TIMEOUT, pulse err[sel], set last_owner=sel, and go to IDLE. rdata is unchanged on timeout.
- mem_ack outside WAIT is ignored, including an ack in the ISSUE cycle.
- Command fields are frozen from grant to completion. Changes on addr/we/wdata or deassertion of req during ISSUE/WAIT are ignored, and the transaction still completes with done/err.
- A requester still holding req in the cycle its done/err is high is treated as a new request. Round-robin then favours the other requester if it is pending.
- gnt[sel]=1 in ISSUE and WAIT. Both gnts are 0 in IDLE. gnt0 and gnt1 are never high together.
- Reset values: state=IDLE, last_owner=1 (so req0 wins the first contention), sel=0, counter=0.
- Reset values, continued: all of gnt0/1, done0/1, err0/1, busy, mem_req, mem_we are 0, and rdata/mem_addr/mem_wdata are 0.
- Reset asserted mid-transaction aborts immediately with no done/err pulse. The port must tolerate the dropped command.

## Timing
- Request sampled at edge N in IDLE → gnt/sel/busy/mem_* valid and mem_req=1 in cycle N+1 (ISSUE).
- Cycle N+2 is the first WAIT cycle.
- mem_ack sampled in WAIT at edge M → done/rdata valid in cycle M+1 while state is IDLE.
- Minimum turnaround with ack in the first WAIT cycle: request edge to done is 3 cycles, so a new grant is possible every 3 cycles.
- Timeout: err is high exactly TIMEOUT+1 cycles after the ISSUE cycle when mem_ack never arrives.
- done/err and a new grant decision happen in the same IDLE cycle. The next mem_req follows one cycle later.
- All outputs are registered. There is no combinational path from req/mem_ack to any output.

## Test plan
- Reset then single read:
  - Stimulus: req0=1, addr0=0x100, we0=0; mem_ack one cycle after mem_req, mem_rdata=0xDEAD.
  - Required: mem_req one cycle with mem_addr=0x100 and sel=0; done0 pulses one cycle; rdata=0xDEAD; done1=err0=0.
- Simultaneous contention from reset:
  - Stimulus: req0=req1=1 held, immediate acks.
  - Required: grants alternate 0,1,0,1 across four transactions; gnt0 and gnt1 never both high.
- Write with frozen command:
  - Stimulus: req1=1, we1=1, wdata1=0x55; wdata1 changes to 0xAA and req1 drops during WAIT.
  - Required: mem_wdata=0x55 throughout; done1 still pulses; rdata unchanged.
- Timeout:
  - Stimulus: TIMEOUT=15, req0, no mem_ack.
  - Required: err0 pulses 16 cycles after ISSUE; done0=0; return to IDLE; a following req1 is granted next.
- Stray ack:
  - Stimulus: mem_ack=1 during IDLE and during the ISSUE cycle.
  - Required: no done/err and no rdata change; the transaction completes only on a WAIT-cycle ack.
- Reset mid-WAIT:
  - Stimulus: reset=0 for one cycle during WAIT.
  - Required: all outputs go to reset values immediately; no done/err; the next req0 is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Two-requester round-robin arbiter and sequencer for a single
//             shared memory port. Requester 0 is instruction fetch and
//             requester 1 is data access. The block picks a winner, freezes
//             its command into the mem_* registers, drives the owner select
//             for the port muxes and runs a req/ack transaction with a
//             timeout. It returns read data and a done or err pulse.
//  Ports    :
//    clk, reset          clock; asynchronous active-low reset
//    req/addr/we/wdata*  per-requester command (held until done/err)
//    gnt0/1              owner indicator, ISSUE through WAIT
//    done0/1, err0/1     one-cycle completion / timeout pulses
//    rdata               last completed read data
//    sel                 owner select for the port muxes (0 = req0)
//    busy                high whenever not IDLE
//    mem_req             one-cycle command strobe
//    mem_addr/we/wdata   registered, frozen command fields
//    mem_ack, mem_rdata  port completion and read data
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              we0,
    input  logic              we1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic              sel,
    output logic              busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // The counter holds the number of WAIT cycles already spent without ack.
    // Aborting when it equals TIMEOUT-1 puts err exactly TIMEOUT+1 cycles
    // after the ISSUE cycle.
    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_last_owner;
    logic [7:0]  r_cnt;
    logic        w_grant;
    logic        w_grant_sel;
    logic        w_done;
    logic        w_err;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and transaction decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_grant_sel  = 1'b0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_grant      = 1'b1;
                    // Under contention the requester that did not own the
                    // port last wins; otherwise the lone requester wins.
                    w_grant_sel  = (req0 && req1) ? ~r_last_owner : req1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // An ack in this cycle is deliberately ignored.
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ack) begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_err        = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs, command capture and timeout counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_owner <= 1'b1;
            r_cnt        <= 8'd0;
            sel          <= 1'b0;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            busy         <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            err0         <= 1'b0;
            err1         <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            rdata        <= '0;
        end else begin
            mem_req <= w_grant;
            done0   <= w_done & ~sel;
            done1   <= w_done &  sel;
            err0    <= w_err  & ~sel;
            err1    <= w_err  &  sel;

            if (w_grant) begin
                sel       <= w_grant_sel;
                gnt0      <= ~w_grant_sel;
                gnt1      <=  w_grant_sel;
                busy      <= 1'b1;
                mem_addr  <= w_grant_sel ? addr1  : addr0;
                mem_we    <= w_grant_sel ? we1    : we0;
                mem_wdata <= w_grant_sel ? wdata1 : wdata0;
            end

            if (w_done || w_err) begin
                gnt0         <= 1'b0;
                gnt1         <= 1'b0;
                busy         <= 1'b0;
                r_last_owner <= sel;
            end

            // Only a completed read updates rdata.
            if (w_done && !mem_we) begin
                rdata <= mem_rdata;
            end

            if (r_state == S_ISSUE) begin
                r_cnt <= 8'd0;
            end else if (r_state == S_WAIT && !mem_ack) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire
